// File: rtl/wbus_mux_reg.sv
// Registered W-bus source selector: picks one of CHANNELS valid/ready sources, either by an
// explicit select port (MODE=0) or round-robin (MODE=1), into a one-entry output register.
module wbus_mux_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODE     = 0,
  localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          select,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_last_q, rr_last_d;

  logic             chosen;
  logic [SEL_W-1:0] grant;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  // Grant selection never looks at in_data, so in_ready has no data dependency.
  always_comb begin : p_grant
    int unsigned idx;
    idx    = 0;
    chosen = 1'b0;
    grant  = '0;
    if (MODE == 0) begin
      if (32'(select) < CHANNELS) begin
        chosen = 1'b1;
        grant  = select;
      end
    end else begin
      // Scan starts just after the last winner and wraps within the populated channels.
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
        idx = 32'(rr_last_q) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!chosen && in_valid[SEL_W'(idx)]) begin
          chosen = 1'b1;
          grant  = SEL_W'(idx);
        end
      end
    end
  end

  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    in_ready = '0;
    if (clr_n && can_load && chosen) in_ready[grant] = 1'b1;
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_last_d   = rr_last_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_chan_d  = grant;
      out_valid_d = 1'b1;
      if (MODE != 0) rr_last_d = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_last_q   <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_wbus_mux_reg.sv
// Bench for wbus_mux_reg: three instances (select/4ch, round-robin/4ch, select/3ch) share one
// stimulus stream; a reference model pushes expected words into per-instance scoreboards.
module tb_wbus_mux_reg;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  select;
  logic        out_ready;

  logic [3:0] ir0, ir1;
  logic [2:0] ir2;
  logic [7:0] od0, od1, od2;
  logic [1:0] oc0, oc1, oc2;
  logic       ov0, ov1, ov2;

  always #5 clk = ~clk;

  wbus_mux_reg #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_sel4 (
    .clk(clk), .clr_n(clr_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir0),
    .select(select), .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(out_ready)
  );

  wbus_mux_reg #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_rr4 (
    .clk(clk), .clr_n(clr_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir1),
    .select(select), .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(out_ready)
  );

  wbus_mux_reg #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u_sel3 (
    .clk(clk), .clr_n(clr_n), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]),
    .in_ready(ir2), .select(select), .out_data(od2), .out_chan(oc2), .out_valid(ov2),
    .out_ready(out_ready)
  );

  int total = 0;
  int bad   = 0;

  int          m_rr    [3];
  bit          m_valid [3];
  logic [9:0]  sb0[$], sb1[$], sb2[$];  // {chan, data}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ch_of(input int k);
    return (k == 2) ? 3 : 4;
  endfunction

  // Reference: which channel the instance should offer in_ready to, -1 for none.
  function automatic int model_grant(input int k);
    int n;
    int idx;
    n = ch_of(k);
    if (k != 1) return (int'(select) < n) ? int'(select) : -1;
    for (int j = 1; j <= n; j++) begin
      idx = (m_rr[k] + j) % n;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic get_dut(input int k, output logic [3:0] ir, output logic [7:0] d,
                         output logic [1:0] c, output logic v);
    case (k)
      0:       begin ir = ir0;          d = od0; c = oc0; v = ov0; end
      1:       begin ir = ir1;          d = od1; c = oc1; v = ov1; end
      default: begin ir = {1'b0, ir2};  d = od2; c = oc2; v = ov2; end
    endcase
  endtask

  task automatic sb_push(input int k, input logic [9:0] e);
    case (k)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic sb_front(input int k, output logic [9:0] e, output bit ok);
    e  = '0;
    ok = 1'b0;
    case (k)
      0:       if (sb0.size() > 0) begin e = sb0[0]; ok = 1'b1; end
      1:       if (sb1.size() > 0) begin e = sb1[0]; ok = 1'b1; end
      default: if (sb2.size() > 0) begin e = sb2[0]; ok = 1'b1; end
    endcase
  endtask

  task automatic sb_drop(input int k);
    case (k)
      0:       void'(sb0.pop_front());
      1:       void'(sb1.pop_front());
      default: void'(sb2.pop_front());
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0;
      m_rr[k]    = ch_of(k) - 1;
    end
    sb0.delete();
    sb1.delete();
    sb2.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    logic [3:0] ir;
    logic [7:0] d;
    logic [1:0] c;
    logic       v;
    for (int k = 0; k < 3; k++) begin
      get_dut(k, ir, d, c, v);
      check($sformatf("%s_valid[%0d]", tag, k), v, 0);
      check($sformatf("%s_data[%0d]", tag, k), d, 0);
      check($sformatf("%s_chan[%0d]", tag, k), c, 0);
      check($sformatf("%s_ready[%0d]", tag, k), ir, 0);
    end
  endtask

  // Called with inputs freshly driven just after a falling edge; returns at the next one.
  task automatic tick();
    int         g;
    logic [3:0] exp_ir, ir;
    logic [7:0] d;
    logic [1:0] c;
    logic       v;
    logic [9:0] e;
    bit         ok, xf;
    #1;
    for (int k = 0; k < 3; k++) begin
      get_dut(k, ir, d, c, v);
      g      = model_grant(k);
      exp_ir = '0;
      if ((!m_valid[k] || out_ready) && g >= 0) exp_ir[g] = 1'b1;
      check($sformatf("in_ready[%0d]", k), ir, exp_ir);
      check($sformatf("out_valid[%0d]", k), v, m_valid[k]);
      if (m_valid[k]) begin
        sb_front(k, e, ok);
        check($sformatf("sb_nonempty[%0d]", k), ok, 1);
        if (ok) begin
          check($sformatf("out_data[%0d]", k), d, e[7:0]);
          check($sformatf("out_chan[%0d]", k), c, e[9:8]);
          if (out_ready) sb_drop(k);
        end
      end
      xf = 1'b0;
      if (exp_ir != 0) xf = in_valid[g];
      if (xf) begin
        sb_push(k, {g[1:0], in_data[g*8 +: 8]});
        if (k == 1) m_rr[k] = g;
      end
      m_valid[k] = xf || (m_valid[k] && !out_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  int         rr_exp [9];
  logic [7:0] exp_word;

  initial begin
    rr_exp    = '{0, 2, 3, 0, 2, 3, 0, 3, 0};
    clr_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    select    = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outs("por");
    clr_n = 1'b1;

    // Explicit select stepping; the 3-channel instance sees select=3 as out of range.
    in_data  = 32'h4433_2211;
    in_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      select = 2'(i);
      tick();
      check("sel_data", od0, 32'h11 * (i + 1));
      check("sel_chan", oc0, i);
    end
    in_valid = '0;
    tick();

    // Back-pressure: hold 8'h22 for 5 cycles while inputs churn.
    in_valid = 4'hF;
    select   = 2'd1;
    tick();
    check("bp_load", od0, 8'h22);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      select  = 2'(i);
      in_data = $urandom;
      tick();
      check("bp_hold", od0, 8'h22);
      check("bp_ready", ir0, 0);
    end
    select    = 2'd3;
    out_ready = 1'b1;
    exp_word  = in_data[31:24];
    tick();
    check("bp_release_valid", ov0, 1);
    check("bp_release_data", od0, exp_word);

    // Asynchronous reset between edges while holding a word.
    in_data  = 32'h0000_005A;
    in_valid = 4'b0001;
    select   = 2'd0;
    tick();
    out_ready = 1'b0;
    #2;
    check("pre_rst_valid", ov0, 1);
    check("pre_rst_data", od0, 8'h5A);
    clr_n = 1'b0;
    #1;
    check_reset_outs("async_rst");
    model_reset();
    @(negedge clk);
    clr_n     = 1'b1;
    out_ready = 1'b1;

    // Round-robin over channels 0,2,3, then channel 2 drops out.
    in_valid = 4'b1101;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) in_valid = 4'b1001;
      in_data = $urandom;
      tick();
      check("rr_order", oc1, rr_exp[i]);
    end

    // Idle cycles must not advance the round-robin pointer.
    in_valid = '0;
    repeat (3) tick();
    check("idle_drained", ov1, 0);
    in_valid = 4'b0010;
    tick();
    check("idle_grant_valid", ov1, 1);
    check("idle_grant_chan", oc1, 1);

    // Back-to-back throughput.
    in_valid = 4'hF;
    for (int i = 0; i < 16; i++) begin
      select   = 2'(i % 4);
      in_data  = $urandom;
      exp_word = in_data[(i % 4)*8 +: 8];
      tick();
      check("thru_valid", ov0, 1);
      check("thru_data", od0, exp_word);
    end
    in_valid = '0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wbus_mux_reg.md
Name: wbus_mux_reg

Overview:
- Parametrised, registered successor to the 2:1 selector used on the SAP-1 W-bus.
- Selects one of CHANNELS sources of WIDTH bits each and captures it into a single output register.
- Each source and the sink use a valid/ready handshake.
- Two modes: explicit-select (MODE=0) and round-robin arbitration (MODE=1); sits between register-file/ALU sources and the shared bus consumer.

Parameters:
- WIDTH, 8, data bits per channel (>=1)
- CHANNELS, 4, number of input channels (2..16)
- MODE, 0, 0 = channel chosen by select port; 1 = round-robin among valid channels, select ignored
- SEL_W, derived localparam = max(1, clog2(CHANNELS)), width of select/out_chan

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  channel i has data
- in_ready  out  CHANNELS  channel i transfer accepted this cycle
- select  in  SEL_W  channel index, MODE=0 only
- out_data  out  WIDTH  registered selected data
- out_chan  out  SEL_W  index of channel that supplied out_data
- out_valid  out  1  output register holds data
- out_ready  in  1  sink accepts out_data this cycle

Behaviour:
- Reset (clr_n=0, async, takes effect without clk): out_data=0, out_chan=0, out_valid=0, rr_last=CHANNELS-1. in_ready=0 while reset is asserted. In-flight data is discarded; no partial transfer.
- Reset release: first load may occur on the first rising edge with clr_n=1.
- can_load = !out_valid || out_ready. Combinational; one-entry pipeline supports full throughput.
- Chosen channel g:
  - MODE=0: g=select if select<CHANNELS; otherwise no channel chosen.
  - MODE=1: g = first i with in_valid[i]=1, scanning rr_last+1, rr_last+2, ... with wrap modulo CHANNELS. No channel chosen if all in_valid=0.
- in_ready[i] = can_load && (i==g) && channel chosen. Combinational from in_valid, select, out_valid, out_ready, rr_last. in_ready never depends on in_data. Exactly one bit high at most.
- Transfer on a rising edge when in_valid[g] && in_ready[g]: out_data<=channel g data, out_chan<=g, out_valid<=1. MODE=1: rr_last<=g.
- On a rising edge with out_valid && out_ready and no new transfer: out_valid<=0. out_data and out_chan keep their last values.
- Simultaneous drain and load in the same cycle: new data replaces old; out_valid stays 1.
- Latency: 1 cycle from input transfer to out_valid.
- Stall (out_valid=1, out_ready=0): out_data and out_chan are held stable. All in_ready=0. Changes to select or in_valid have no effect on the held word. rr_last does not move.
- MODE=0 invalid select (>=CHANNELS): no transfer, all in_ready=0, output register drains normally.
- MODE=1 fairness: a continuously valid channel is granted within CHANNELS transfers. rr_last advances only on a transfer, never on idle cycles.
- CHANNELS not a power of two: wrap skips indices >= CHANNELS.
- No combinational path from in_data to outputs. out_valid is never 1 without a completed transfer.

Test Plan:
- Reset: drive clr_n=0 mid-stream with out_valid=1 and out_data=8'h5A, between clock edges -> out_valid=0, out_data=0, out_chan=0 immediately, before the next edge.
- MODE=0 selection, CHANNELS=4:
  - Stimulus: in_data = {8'h44,8'h33,8'h22,8'h11}, all valid, out_ready=1, select stepping 0,1,2,3.
  - Required: out_data = 11,22,33,44 on consecutive cycles, one cycle late; out_chan = 0..3.
  - Check that in_ready is one-hot and matches select.
- Back-pressure: out_ready=0 for 5 cycles after load of 8'h22; change select and in_data meanwhile -> out_data stays 8'h22, all in_ready=0. out_ready=1 then loads the new selection next edge with no bubble.
- MODE=1 round-robin: channels 0, 2, 3 valid continuously, out_ready=1 -> grant order 0,2,3,0,2,3. Drop channel 2 mid-sequence -> order continues 3,0,3,0.
- MODE=1 idle / invalid select:
  - MODE=1, all in_valid=0 for 3 cycles, then only channel 1 valid: out_valid drains to 0, rr_last unchanged, next grant is channel 1.
  - MODE=0, select=3 with CHANNELS=3: no transfer, all in_ready=0.
- Throughput: 16 back-to-back words with out_ready=1 -> 16 transfers in 16 consecutive cycles, out_valid continuously 1 from cycle 1.
